select_scanner: RTL and testbench

SELECT_SCANNER -- requirements
Module: select_scanner

---
 rtl/select_scanner.sv | 86 ++++++++
 tb/tb_select_scanner.sv | 122 ++++++++++++
 2 files changed

// File: rtl/select_scanner.sv
// select_scanner: steps a registered 4:1 mux select through 0..3, holding each value for a latched dwell.
module select_scanner #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [3:0]         d_in,
  input  logic               start,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  input  logic               abort,
  output logic [3:0]         d,
  output logic [1:0]         s,
  output logic               busy,
  output logic               step,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;
  state_t state, state_n;
  logic [DWELL_W-1:0] cnt, cnt_n, dwell_l, dwell_n;
  logic [3:0] d_n;
  logic [1:0] s_n;
  logic mode_l, mode_n, step_n, done_n, tc;
  assign tc = cnt == dwell_l - DWELL_W'(1);
  always_comb begin
    state_n = state;
    d_n = d;
    s_n = s;
    cnt_n = cnt;
    mode_n = mode_l;
    dwell_n = dwell_l;
    step_n = 1'b0;
    done_n = 1'b0;
    case (state)
      IDLE: begin
        d_n = load ? d_in : d;
        if (start) begin
          state_n = SCAN;
          mode_n = mode;
          dwell_n = (dwell == '0) ? DWELL_W'(1) : dwell;
          cnt_n = '0;
          s_n = 2'd0;
        end
      end
      SCAN: begin
        cnt_n = tc ? '0 : cnt + DWELL_W'(1);
        if (abort) begin
          state_n = IDLE;
          s_n = 2'd0;
          cnt_n = '0;
        end else if (tc) begin
          // s wraps to 0 on the last slot either way; only mode decides stop vs continue
          s_n = s + 2'd1;
          step_n = (s != 2'd3) || mode_l;
          done_n = (s == 2'd3) && !mode_l;
          state_n = done_n ? DONE : SCAN;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      d <= '0;
      s <= '0;
      cnt <= '0;
      mode_l <= 1'b0;
      dwell_l <= DWELL_W'(1);
      busy <= 1'b0;
      step <= 1'b0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      d <= d_n;
      s <= s_n;
      cnt <= cnt_n;
      mode_l <= mode_n;
      dwell_l <= dwell_n;
      busy <= state_n == SCAN;
      step <= step_n;
      done <= done_n;
    end
  end
endmodule

// File: tb/tb_select_scanner.sv
// tb_select_scanner: random and directed scoreboard bench for select_scanner against a time-based scan model.
module tb_select_scanner;
  logic clk = 1'b0;
  logic rst, load, start, mode, abort;
  logic [3:0] d_in, d;
  logic [7:0] dwell;
  logic [1:0] s;
  logic busy, step, done;
  typedef struct packed {
    logic [3:0] d;
    logic [1:0] s;
    logic busy;
    logic step;
    logic done;
  } obs_t;
  obs_t q[$];
  int errors = 0;
  int checks = 0;
  int phase = 0;
  int t = 0;
  int m_dw = 1;
  bit m_mode = 1'b0;
  logic [3:0] m_d = 4'd0;
  select_scanner #(.DWELL_W(8)) dut (
    .clk(clk), .rst(rst), .load(load), .d_in(d_in), .start(start), .mode(mode),
    .dwell(dwell), .abort(abort), .d(d), .s(s), .busy(busy), .step(step), .done(done)
  );
  always #5 clk = ~clk;
  // Model: phase 0 idle, 1 scanning, 2 done; t counts cycles since the first scan cycle.
  task automatic cyc(input logic r, input logic ld, input logic [3:0] di, input logic st,
                     input logic md, input logic [7:0] dw, input logic ab);
    obs_t e;
    @(negedge clk);
    rst = r; load = ld; d_in = di; start = st; mode = md; dwell = dw; abort = ab;
    e = '0;
    if (r) begin
      phase = 0;
      m_d = 4'd0;
    end else if (phase == 0) begin
      if (ld) m_d = di;
      if (st) begin
        phase = 1;
        t = 0;
        m_dw = (dw == 0) ? 1 : int'(dw);
        m_mode = md;
      end
    end else if (phase == 1) begin
      if (ab) phase = 0;
      else begin
        t++;
        if (!m_mode && t == 4 * m_dw) begin
          phase = 2;
          e.done = 1'b1;
        end else begin
          e.s = 2'((t / m_dw) % 4);
          e.step = (t % m_dw) == 0;
        end
      end
    end else phase = 0;
    e.d = m_d;
    e.busy = phase == 1;
    q.push_back(e);
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 4'hF, 0, 1, 8'd7, 0);
  endtask
  initial forever begin
    obs_t g, e;
    @(posedge clk);
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      g = '{d: d, s: s, busy: busy, step: step, done: done};
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got d=%h s=%0d busy=%b step=%b done=%b want d=%h s=%0d busy=%b step=%b done=%b",
                 $time, g.d, g.s, g.busy, g.step, g.done, e.d, e.s, e.busy, e.step, e.done);
      end
    end
  end
  initial begin
    rst = 1; load = 0; d_in = 0; start = 0; mode = 0; dwell = 0; abort = 0;
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 1, 4'h7, 1, 1, 8'd2, 1);
    idle(3);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 1, 4'b1010, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 8'd3, 0);
    idle(16);
    cyc(0, 0, 0, 1, 1, 8'd1, 0);
    idle(10);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(2);
    cyc(0, 0, 0, 1, 0, 8'd0, 0);
    idle(6);
    cyc(0, 1, 4'b0011, 1, 0, 8'd4, 0);
    for (int i = 0; i < 9; i++) cyc(0, 1, 4'b0101, 1, 1, 8'd1, 0);
    cyc(0, 0, 0, 0, 0, 0, 1);
    idle(3);
    cyc(0, 0, 0, 1, 1, 8'd2, 0);
    idle(6);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 1, 0, 8'd2, 0);
    idle(10);
    cyc(0, 1, 4'hC, 1, 0, 8'd255, 0);
    idle(1025);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 99) < 2, $urandom_range(0, 4) == 0, 4'($urandom),
          $urandom_range(0, 4) == 0, 1'($urandom), 8'($urandom_range(0, 5)),
          $urandom_range(0, 19) == 0);
    @(posedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
